// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants
// for the +/-5 step ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        SUB_OUT,
        ADD,
        ADD_OUT,
        DONE
    } state_t;

    localparam logic DIR_MINUS = 1'b0;
    localparam logic DIR_PLUS  = 1'b1;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Constant applied by the external ALU.
    localparam int STEP = 5;

endpackage

// File: rtl/alu_seq_ctrl_chk.sv
// nb_bound_chk: combinational legality test
// for one ALU step result.
module nb_bound_chk
    import alu_seq_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int CELLS = 25
) (
    input  logic            step,
    input  logic [SIZE:0]   res,
    input  logic            sign,
    input  logic [SIZE-1:0] opnd,
    output logic            valid
);

    localparam logic [SIZE:0]   CELLS_R = (SIZE+1)'(CELLS);
    localparam logic [SIZE-1:0] CELLS_O = SIZE'(CELLS);

    logic opnd_ok;
    logic res_ok;

    // Negative results are always out; a plus step
    // must also stay below the cell count.
    always_comb begin
        opnd_ok = opnd < CELLS_O;
        res_ok  = !sign;
        if (step == OP_ADD) begin
            res_ok = !sign && (res < CELLS_R);
        end
        valid = opnd_ok && res_ok;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: drives the ALU -5 then +5 and streams legal
// neighbours. ALU_SEQ_STATS_EN adds scan/reject counters.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int CELLS = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            use_alt,
    input  logic [SIZE-1:0] cur,
    input  logic [SIZE-1:0] alt,
    output logic [SIZE-1:0] alu_in1,
    output logic [SIZE-1:0] alu_in2,
    output logic            alu_op,
    output logic            alu_iseq,
    input  logic [SIZE:0]   alu_res,
    input  logic            alu_sign,
    output logic            busy,
    output logic            nb_valid,
    input  logic            nb_ready,
    output logic [SIZE-1:0] nb_idx,
    output logic            nb_dir,
    output logic            done,
    output logic [1:0]      nb_count
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [7:0]      stat_scans,
    output logic [7:0]      stat_reject
`endif
);

    state_t          state;
    state_t          nxt;
    logic [SIZE-1:0] opnd;
    logic            vld_q;
    logic            chk_valid;
    logic            step_st;
    logic            out_st;

    assign opnd    = alu_iseq ? alu_in2 : alu_in1;
    assign step_st = (state == SUB) || (state == ADD);
    assign out_st  = (state == SUB_OUT) || (state == ADD_OUT);

    assign busy     = state != IDLE;
    assign alu_op   = (state == ADD) ? OP_ADD : OP_SUB;
    assign nb_valid = out_st && vld_q;
    assign nb_dir   = (state == ADD_OUT) ? DIR_PLUS : DIR_MINUS;
    assign done     = state == DONE;

    nb_bound_chk #(
        .SIZE  (SIZE),
        .CELLS (CELLS)
    ) u_chk (
        .step  (alu_op),
        .res   (alu_res),
        .sign  (alu_sign),
        .opnd  (opnd),
        .valid (chk_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state; output states wait on the handshake
    // only when they actually hold a neighbour.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = SUB;
            SUB:     nxt = SUB_OUT;
            SUB_OUT: if (!vld_q || nb_ready) nxt = ADD;
            ADD:     nxt = ADD_OUT;
            ADD_OUT: if (!vld_q || nb_ready) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand latch, step result capture, emit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_iseq <= 1'b0;
            nb_idx   <= '0;
            vld_q    <= 1'b0;
            nb_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                alu_in1  <= cur;
                alu_in2  <= alt;
                alu_iseq <= use_alt;
                nb_count <= '0;
            end
            if (step_st) begin
                nb_idx <= alu_res[SIZE-1:0];
                vld_q  <= chk_valid;
            end
            if (nb_valid && nb_ready) begin
                nb_count <= nb_count + 2'd1;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Saturating scan and reject counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_scans  <= '0;
            stat_reject <= '0;
        end else begin
            if (done && stat_scans != 8'hFF) begin
                stat_scans <= stat_scans + 8'd1;
            end
            if (step_st && !chk_valid && stat_reject != 8'hFF) begin
                stat_reject <= stat_reject + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl
// with a behavioural +/-5 ALU.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       use_alt = 1'b0;
    logic [4:0] cur = '0;
    logic [4:0] alt = '0;
    logic [4:0] alu_in1;
    logic [4:0] alu_in2;
    logic       alu_op;
    logic       alu_iseq;
    logic [5:0] alu_res;
    logic       alu_sign;
    logic       busy;
    logic       nb_valid;
    logic       nb_ready = 1'b0;
    logic [4:0] nb_idx;
    logic       nb_dir;
    logic       done;
    logic [1:0] nb_count;
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] stat_scans;
    logic [7:0] stat_reject;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [15:0] got;
    logic [15:0] exp;
    logic [4:0]  aop;

    always #5 clk = ~clk;

    // Behavioural ALU: in1/in2 selected by iseq, -5 or +5.
    always_comb begin
        aop     = alu_iseq ? alu_in2 : alu_in1;
        alu_res = alu_op ? ({1'b0, aop} + 6'd5) : ({1'b0, aop} - 6'd5);
    end
    assign alu_sign = alu_res[5];

    alu_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .use_alt  (use_alt),
        .cur      (cur),
        .alt      (alt),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_op   (alu_op),
        .alu_iseq (alu_iseq),
        .alu_res  (alu_res),
        .alu_sign (alu_sign),
        .busy     (busy),
        .nb_valid (nb_valid),
        .nb_ready (nb_ready),
        .nb_idx   (nb_idx),
        .nb_dir   (nb_dir),
        .done     (done),
        .nb_count (nb_count)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_scans  (stat_scans),
        .stat_reject (stat_reject)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Called mid-cycle 0 in IDLE; returns mid-cycle 1.
    task automatic begin_scan(input logic [4:0] c, input logic [4:0] a,
                              input logic u);
        cur = c;
        alt = a;
        use_alt = u;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nvec++;
        got = {6'd0, busy, nb_valid, done, nb_count, alu_op, alu_iseq, nb_dir, nb_idx[1:0]};
        exp = 16'd0;
        if (got !== exp) begin
            nerr++;
            $display("FAIL reset_ctrl got %h want %h", got, exp);
        end
        nvec++;
        got = {1'b0, alu_in1, alu_in2, nb_idx};
        exp = 16'd0;
        if (got !== exp) begin
            nerr++;
            $display("FAIL reset_data got %h want %h", got, exp);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        nb_ready = 1'b1;
        begin_scan(5'd12, 5'd0, 1'b0);
        nvec++;
        got = {8'd0, busy, alu_op, nb_valid, alu_in1};
        exp = {8'd0, 1'b1, 1'b0, 1'b0, 5'd12};
        if (got !== exp) begin
            nerr++;
            $display("FAIL basic_c1 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b0, 5'd7};
        if (got !== exp) begin
            nerr++;
            $display("FAIL basic_c2 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {14'd0, nb_valid, alu_op};
        exp = {14'd0, 1'b0, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL basic_c3 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b1, 5'd17};
        if (got !== exp) begin
            nerr++;
            $display("FAIL basic_c4 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {14'd0, done, busy};
        exp = {14'd0, 1'b1, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL basic_c5 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {12'd0, done, busy, nb_count};
        exp = {12'd0, 1'b0, 1'b0, 2'd2};
        if (got !== exp) begin
            nerr++;
            $display("FAIL basic_c6 got %h want %h", got, exp);
        end
    endtask

    task automatic test_sub_reject();
        nb_ready = 1'b1;
        begin_scan(5'd3, 5'd0, 1'b0);
        nvec++;
        got = {14'd0, nb_count};
        exp = 16'd0;
        if (got !== exp) begin
            nerr++;
            $display("FAIL rej_clear got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {10'd0, nb_valid, nb_idx};
        exp = {10'd0, 1'b0, 5'd30};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rej_c2 got %h want %h", got, exp);
        end
        tick();
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b1, 5'd8};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rej_c4 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {15'd0, done};
        exp = {15'd0, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rej_c5 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {12'd0, done, busy, nb_count};
        exp = {12'd0, 1'b0, 1'b0, 2'd1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rej_c6 got %h want %h", got, exp);
        end
    endtask

    task automatic test_alt();
        nb_ready = 1'b1;
        begin_scan(5'd0, 5'd22, 1'b1);
        nvec++;
        got = {5'd0, alu_iseq, alu_in1, alu_in2};
        exp = {5'd0, 1'b1, 5'd0, 5'd22};
        if (got !== exp) begin
            nerr++;
            $display("FAIL alt_c1 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b0, 5'd17};
        if (got !== exp) begin
            nerr++;
            $display("FAIL alt_c2 got %h want %h", got, exp);
        end
        tick();
        tick();
        nvec++;
        got = {14'd0, nb_valid, alu_iseq};
        exp = {14'd0, 1'b0, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL alt_c4 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {14'd0, done, alu_iseq};
        exp = {14'd0, 1'b1, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL alt_c5 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {13'd0, busy, nb_count};
        exp = {13'd0, 1'b0, 2'd1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL alt_c6 got %h want %h", got, exp);
        end
    endtask

    task automatic test_back_pressure();
        nb_ready = 1'b0;
        begin_scan(5'd12, 5'd0, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            nvec++;
            got = {9'd0, nb_valid, nb_dir, nb_idx};
            exp = {9'd0, 1'b1, 1'b0, 5'd7};
            if (got !== exp) begin
                nerr++;
                $display("FAIL bp_hold_c%0d got %h want %h", k, got, exp);
            end
            if (k == 3) begin
                cur = 5'd3;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        nb_ready = 1'b1;
        tick();
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b1, 5'd17};
        if (got !== exp) begin
            nerr++;
            $display("FAIL bp_c7 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {15'd0, done};
        exp = {15'd0, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL bp_c8 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {7'd0, done, busy, nb_count, alu_in1};
        exp = {7'd0, 1'b0, 1'b0, 2'd2, 5'd12};
        if (got !== exp) begin
            nerr++;
            $display("FAIL bp_c9 got %h want %h", got, exp);
        end
        tick();
        nvec++;
        got = {15'd0, busy};
        exp = 16'd0;
        if (got !== exp) begin
            nerr++;
            $display("FAIL bp_no_queue got %h want %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        nb_ready = 1'b1;
        begin_scan(5'd12, 5'd0, 1'b0);
        tick();
        tick();
        tick();
        nvec++;
        got = {15'd0, nb_valid};
        exp = {15'd0, 1'b1};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rstmid_pre got %h want %h", got, exp);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        got = {8'd0, nb_valid, busy, done, alu_in1};
        exp = 16'd0;
        if (got !== exp) begin
            nerr++;
            $display("FAIL rstmid_async got %h want %h", got, exp);
        end
        tick();
        rst_n = 1'b1;
        tick();
        begin_scan(5'd12, 5'd0, 1'b0);
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b0, 5'd7};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rstmid_c2 got %h want %h", got, exp);
        end
        tick();
        tick();
        nvec++;
        got = {9'd0, nb_valid, nb_dir, nb_idx};
        exp = {9'd0, 1'b1, 1'b1, 5'd17};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rstmid_c4 got %h want %h", got, exp);
        end
        tick();
        tick();
        nvec++;
        got = {13'd0, busy, nb_count};
        exp = {13'd0, 1'b0, 2'd2};
        if (got !== exp) begin
            nerr++;
            $display("FAIL rstmid_c6 got %h want %h", got, exp);
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        nvec++;
        got = {stat_scans, stat_reject};
        exp = 16'd0;
        if (got !== exp) begin
            nerr++;
            $display("FAIL stats_reset got %h want %h", got, exp);
        end
        nb_ready = 1'b1;
        begin_scan(5'd12, 5'd0, 1'b0);
        repeat (5) tick();
        begin_scan(5'd3, 5'd0, 1'b0);
        repeat (5) tick();
        begin_scan(5'd0, 5'd22, 1'b1);
        repeat (5) tick();
        nvec++;
        got = {stat_scans, stat_reject};
        exp = {8'd3, 8'd2};
        if (got !== exp) begin
            nerr++;
            $display("FAIL stats_count got %h want %h", got, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sub_reject();
        test_alt();
        test_back_pressure();
        test_reset_mid();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the ±5 step ALU. On a start request it latches a cell index (current or alternate operand) and drives the ALU twice, first with op 0 (index−5) and then with op 1 (index+5). It bounds-checks each result against the grid size and streams the legal neighbour indices out over a valid/ready handshake. It sits between the grid-walk FSM and the ALU; the ALU stays a separate instance whose ports this block drives.

## Interface
- SIZE, 5, operand width; ALU result is SIZE+1 bits
- CELLS, 25, number of legal cell indices (0..CELLS−1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  scan request, sampled only in IDLE
- use_alt  in  1  0: scan cur, 1: scan alt; latched with start
- cur  in  SIZE  current cell index
- alt  in  SIZE  alternate cell index
- alu_in1 / alu_in2  out  SIZE  latched cur / alt, to ALU in1 / in2
- alu_op  out  1  to ALU ALUop (0 = −5, 1 = +5)
- alu_iseq  out  1  to ALU iseq (latched use_alt)
- alu_res  in  SIZE+1  ALU res
- alu_sign  in  1  ALU sign (res[SIZE])
- busy  out  1  high in every state except IDLE
- nb_valid  out  1  neighbour available
- nb_ready  in  1  consumer accepts neighbour
- nb_idx  out  SIZE  neighbour index
- nb_dir  out  1  0 = minus step, 1 = plus step
- done  out  1  one-cycle pulse at scan end
- nb_count  out  2  neighbours emitted in last scan, held until next start

## Operation
- States: IDLE → SUB → SUB_OUT → ADD → ADD_OUT → DONE → IDLE.
- IDLE, start=1: latch cur, alt and use_alt. Clear nb_count. Go to SUB.
- SUB / ADD: drive alu_op 0 / 1. Register alu_res[SIZE−1:0] into nb_idx. Register the validity bit.
- Validity:
  - SUB: alu_sign==0.
  - ADD: alu_sign==0 and alu_res < CELLS. Sums ≥32 set sign and are therefore rejected.
  - Either step: if the selected operand is ≥ CELLS, both results are invalid.
- SUB_OUT / ADD_OUT, valid:
  - assert nb_valid, with nb_dir = 0 / 1.
  - Hold nb_idx, nb_dir and nb_valid stable until nb_ready=1.
  - On the handshake cycle increment nb_count, then advance.
- SUB_OUT / ADD_OUT, invalid: nb_valid stays low. Stay exactly one cycle, then advance.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored. No queueing.
- alu_in1 and alu_in2 always reflect the latched operands. alu_iseq is held for the whole scan.

## Timing
- Reset values: all outputs 0, state IDLE, latched operands 0.
- rst_n low at any time returns to IDLE immediately (asynchronously) and drops nb_valid, done and busy. An in-flight scan is abandoned, not resumed.
- Relative to the start cycle (cycle 0), with nb_ready held high:
  - SUB in cycle 1, SUB_OUT in cycle 2.
  - ADD in cycle 3, ADD_OUT in cycle 4.
  - done in cycle 5. busy is high in cycles 1–5.
  - Every cycle nb_ready is low while nb_valid is high adds one cycle.
- The ALU path is combinational within SUB/ADD; its result is registered at the end of that cycle.
- nb_ready may be high before nb_valid.

## Configuration
- ALU_SEQ_STATS_EN defined adds two outputs:
  - stat_scans [7:0]: incremented on each done.
  - stat_reject [7:0]: incremented on each invalid step.
  - Both saturate at 255 and are cleared only by rst_n.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

## Structure
- alu_seq_pkg holds:
  - the state enum (IDLE, SUB, SUB_OUT, ADD, ADD_OUT, DONE)
  - DIR_MINUS = 0, DIR_PLUS = 1
  - OP_SUB = 0, OP_ADD = 1
  - STEP = 5, documenting the ALU constant
- One sub-module, nb_bound_chk: combinational. Takes the step, the result, the sign and the operand; returns the valid bit.

## Test plan
- cur=12, use_alt=0, nb_ready=1 → nb_idx=7/dir 0 in cycle 2, nb_idx=17/dir 1 in cycle 4, done in cycle 5, nb_count=2.
- cur=3 → SUB gives res=6'b111110 (sign=1) and is rejected, no valid in cycle 2. nb_idx=8/dir 1 in cycle 4. nb_count=1.
- alt=22, cur=0, use_alt=1 → alu_iseq=1 for the whole scan. 17 emitted; 27 rejected because 27 ≥ 25. nb_count=1.
- cur=12, nb_ready low for 3 cycles in SUB_OUT → nb_valid=1 and nb_idx=7 held stable. done arrives in cycle 8. start pulses during busy are ignored.
- rst_n low during ADD_OUT → nb_valid, busy and done are 0 at once. After release, start with cur=12 completes normally.
- ALU_SEQ_STATS_EN defined; scans of cur=12, cur=3, then alt=22 → stat_scans=3, stat_reject=2.
